// File: rtl/input_bank_pkg.sv
// Shared types and helpers for the input_bank operand loader.
package input_bank_pkg;

  // Widest select the helper functions accept; wider banks are not supported.
  localparam int MAX_SLOTS = 64;
  localparam int IDX_MAX_W = 6;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 32'sd1;
      end
    end
    return result;
  endfunction

  // True when exactly one bit of the select is set.
  function automatic logic onehot_valid(input logic [MAX_SLOTS-1:0] sel);
    logic [7:0] ones;
    ones = 8'd0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      ones = ones + {7'd0, sel[i]};
    end
    return (ones == 8'd1);
  endfunction

  // Position of the highest set bit; only meaningful for a valid one-hot select.
  function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [MAX_SLOTS-1:0] sel);
    logic [IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      if (sel[i]) begin
        idx = IDX_MAX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/input_bank_if.sv
// Write-side and frame-side signals between the operand source, input_bank and the sorter.
interface input_bank_if
  import input_bank_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int DATA_W     = 4,
  parameter int ONEHOT_SEL = 1,
  parameter int CNT_W      = 8
);
  localparam int SEL_W = (ONEHOT_SEL != 0) ? NUM_SLOTS : clog2(NUM_SLOTS);

  logic                          clr;
  logic                          wr_en;
  logic [SEL_W-1:0]              wr_sel;
  logic [DATA_W-1:0]             wr_data;
  logic                          frame_ready;
  logic                          frame_valid;
  logic [NUM_SLOTS*DATA_W-1:0]   unsorted_flat;
  logic [NUM_SLOTS-1:0]          slot_loaded;
  logic                          sel_err;
  logic                          wr_drop;
  logic                          ovr;
  logic [CNT_W-1:0]              frame_cnt;

  modport master (
    output clr, wr_en, wr_sel, wr_data, frame_ready,
    input  frame_valid, unsorted_flat, slot_loaded, sel_err, wr_drop, ovr, frame_cnt
  );

  modport slave (
    input  clr, wr_en, wr_sel, wr_data, frame_ready,
    output frame_valid, unsorted_flat, slot_loaded, sel_err, wr_drop, ovr, frame_cnt
  );
endinterface

// File: rtl/input_sel_decode.sv
// Turns a one-hot or binary slot select into a slot index plus a validity flag.
module input_sel_decode
  import input_bank_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int ONEHOT_SEL = 1,
  parameter int SEL_W      = NUM_SLOTS,
  parameter int IDX_W      = 2
) (
  input  logic [SEL_W-1:0] wr_sel,
  output logic [IDX_W-1:0] slot_idx,
  output logic             sel_ok
);

  logic [MAX_SLOTS-1:0] sel_ext_s;
  logic [IDX_MAX_W-1:0] idx_full_s;

  // Widen the select to the helper width, then decode it per select mode.
  always_comb begin
    sel_ext_s = '0;
    sel_ext_s[SEL_W-1:0] = wr_sel;
    if (ONEHOT_SEL != 0) begin
      sel_ok     = onehot_valid(sel_ext_s);
      idx_full_s = onehot_to_idx(sel_ext_s);
    end else begin
      sel_ok     = (sel_ext_s < 64'(NUM_SLOTS));
      idx_full_s = sel_ext_s[IDX_MAX_W-1:0];
    end
    slot_idx = idx_full_s[IDX_W-1:0];
  end

endmodule

// File: rtl/input_bank.sv
// Operand register bank: fills NUM_SLOTS slots one write per cycle, then holds the
// frame for the sorter until a valid/ready handshake releases it.
module input_bank
  import input_bank_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int DATA_W     = 4,
  parameter int ONEHOT_SEL = 1,
  parameter int CNT_W      = 8
) (
  input logic        clk,
  input logic        rst,
  input_bank_if.slave bus
);

  localparam int SEL_W = (ONEHOT_SEL != 0) ? NUM_SLOTS : clog2(NUM_SLOTS);
  localparam int IDX_W = clog2(NUM_SLOTS);

  state_e                               state_r;
  logic [NUM_SLOTS-1:0][DATA_W-1:0]     slot_r;
  logic [NUM_SLOTS-1:0]                 loaded_r;
  logic                                 frame_valid_r;
  logic                                 sel_err_r;
  logic                                 wr_drop_r;
  logic                                 ovr_r;
  logic [CNT_W-1:0]                     cnt_r;

  logic [IDX_W-1:0]                     slot_idx_s;
  logic                                 sel_ok_s;
  logic [NUM_SLOTS-1:0]                 wr_mask_s;
  logic [NUM_SLOTS-1:0]                 loaded_next_s;
  logic                                 hit_s;
  logic                                 all_loaded_s;

  input_sel_decode #(
    .NUM_SLOTS  (NUM_SLOTS),
    .ONEHOT_SEL (ONEHOT_SEL),
    .SEL_W      (SEL_W),
    .IDX_W      (IDX_W)
  ) u_sel_decode (
    .wr_sel   (bus.wr_sel),
    .slot_idx (slot_idx_s),
    .sel_ok   (sel_ok_s)
  );

  // Slot mask of the current write and the loaded-flag outlook if it lands.
  always_comb begin
    wr_mask_s = '0;
    if (sel_ok_s) begin
      wr_mask_s[slot_idx_s] = 1'b1;
    end else begin
      wr_mask_s = '0;
    end
    loaded_next_s = loaded_r | wr_mask_s;
    hit_s         = |(loaded_r & wr_mask_s);
    all_loaded_s  = &loaded_next_s;
  end

  // FILL/HOLD control, slot storage, event pulses and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= FILL;
      slot_r        <= '0;
      loaded_r      <= '0;
      frame_valid_r <= 1'b0;
      sel_err_r     <= 1'b0;
      wr_drop_r     <= 1'b0;
      ovr_r         <= 1'b0;
      cnt_r         <= '0;
    end else begin
      sel_err_r <= 1'b0;
      wr_drop_r <= 1'b0;
      ovr_r     <= 1'b0;
      if (bus.clr) begin
        // Clear silently discards any write in the same cycle; slot data is kept.
        state_r       <= FILL;
        loaded_r      <= '0;
        frame_valid_r <= 1'b0;
      end else if (frame_valid_r && bus.frame_ready) begin
        // Handshake: release the frame, keep the data, refuse a coincident write.
        state_r       <= FILL;
        loaded_r      <= '0;
        frame_valid_r <= 1'b0;
        cnt_r         <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        wr_drop_r     <= bus.wr_en;
      end else begin
        case (state_r)
          FILL: begin
            if (bus.wr_en) begin
              if (sel_ok_s) begin
                slot_r[slot_idx_s] <= bus.wr_data;
                loaded_r           <= loaded_next_s;
                ovr_r              <= hit_s;
                if (all_loaded_s) begin
                  state_r       <= HOLD;
                  frame_valid_r <= 1'b1;
                end
              end else begin
                sel_err_r <= 1'b1;
              end
            end
          end
          HOLD: begin
            wr_drop_r <= bus.wr_en;
          end
          default: begin
            state_r       <= FILL;
            loaded_r      <= '0;
            frame_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.frame_valid   = frame_valid_r;
  assign bus.unsorted_flat = slot_r;
  assign bus.slot_loaded   = loaded_r;
  assign bus.sel_err       = sel_err_r;
  assign bus.wr_drop       = wr_drop_r;
  assign bus.ovr           = ovr_r;
  assign bus.frame_cnt     = cnt_r;

endmodule

// File: tb/tb_input_bank.sv
// Self-checking bench for input_bank: three configurations (one-hot x4, binary x3,
// one-hot x4 with a 2-bit counter) driven side by side against a behavioural model.
module tb_input_bank;

  logic clk;
  logic rst;

  input_bank_if #(.NUM_SLOTS(4), .DATA_W(4), .ONEHOT_SEL(1), .CNT_W(8)) bus0 ();
  input_bank_if #(.NUM_SLOTS(3), .DATA_W(4), .ONEHOT_SEL(0), .CNT_W(8)) bus1 ();
  input_bank_if #(.NUM_SLOTS(4), .DATA_W(4), .ONEHOT_SEL(1), .CNT_W(2)) bus2 ();

  input_bank #(.NUM_SLOTS(4), .DATA_W(4), .ONEHOT_SEL(1), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  input_bank #(.NUM_SLOTS(3), .DATA_W(4), .ONEHOT_SEL(0), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  input_bank #(.NUM_SLOTS(4), .DATA_W(4), .ONEHOT_SEL(1), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state for one bank: what the frame looks like, not how it is built.
  typedef struct packed {
    logic        held;
    logic [3:0]  loaded;
    logic [15:0] data;
    logic [31:0] cnt;
    logic        sel_err;
    logic        wr_drop;
    logic        ovr;
  } model_t;

  int     n_slots [3] = '{4, 3, 4};
  int     onehot  [3] = '{1, 0, 1};
  int     cnt_mod [3] = '{256, 256, 4};
  model_t mdl     [3];

  logic   in_clr [3];
  logic   in_we  [3];
  int     in_sel [3];
  int     in_dat [3];
  logic   in_rdy [3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t m;
    m = '0;
    return m;
  endfunction

  // One clock edge of the bank as described in words: clear, then release, then write.
  function automatic model_t model_step(model_t m, int k, logic clr, logic we, int sel, int dat, logic rdy);
    int  idx;
    logic ok;
    m.sel_err = 1'b0;
    m.wr_drop = 1'b0;
    m.ovr     = 1'b0;
    if (clr) begin
      m.held   = 1'b0;
      m.loaded = 4'd0;
      return m;
    end
    if (m.held) begin
      if (rdy) begin
        m.held   = 1'b0;
        m.loaded = 4'd0;
        m.cnt    = (m.cnt + 1) % cnt_mod[k];
      end
      m.wr_drop = we;
      return m;
    end
    if (!we) return m;
    if (onehot[k] != 0) begin
      ok  = ($countones(sel) == 1);
      idx = ok ? $clog2(sel) : 0;
    end else begin
      ok  = (sel < n_slots[k]);
      idx = sel;
    end
    if (!ok) begin
      m.sel_err = 1'b1;
    end else begin
      m.ovr              = m.loaded[idx];
      m.loaded[idx]      = 1'b1;
      m.data[idx*4 +: 4] = dat[3:0];
      m.held             = (int'(m.loaded) == (1 << n_slots[k]) - 1);
    end
    return m;
  endfunction

  task automatic check_dut(input int k, input logic fv, input logic [15:0] flat, input logic [3:0] ld,
                           input logic se, input logic wd, input logic ov, input logic [7:0] cnt);
    check_eq($sformatf("d%0d_frame_valid", k), {31'd0, fv}, {31'd0, mdl[k].held});
    check_eq($sformatf("d%0d_unsorted_flat", k), {16'd0, flat}, {16'd0, mdl[k].data});
    check_eq($sformatf("d%0d_slot_loaded", k), {28'd0, ld}, {28'd0, mdl[k].loaded});
    check_eq($sformatf("d%0d_sel_err", k), {31'd0, se}, {31'd0, mdl[k].sel_err});
    check_eq($sformatf("d%0d_wr_drop", k), {31'd0, wd}, {31'd0, mdl[k].wr_drop});
    check_eq($sformatf("d%0d_ovr", k), {31'd0, ov}, {31'd0, mdl[k].ovr});
    check_eq($sformatf("d%0d_frame_cnt", k), {24'd0, cnt}, mdl[k].cnt);
  endtask

  task automatic check_all();
    check_dut(0, bus0.frame_valid, bus0.unsorted_flat, bus0.slot_loaded, bus0.sel_err, bus0.wr_drop, bus0.ovr, bus0.frame_cnt);
    check_dut(1, bus1.frame_valid, {4'd0, bus1.unsorted_flat}, {1'b0, bus1.slot_loaded}, bus1.sel_err, bus1.wr_drop, bus1.ovr, bus1.frame_cnt);
    check_dut(2, bus2.frame_valid, bus2.unsorted_flat, bus2.slot_loaded, bus2.sel_err, bus2.wr_drop, bus2.ovr, {6'd0, bus2.frame_cnt});
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      in_clr[k] = 1'b0; in_we[k] = 1'b0; in_sel[k] = 0; in_dat[k] = 0; in_rdy[k] = 1'b0;
    end
  endtask

  task automatic drive(input int k, input logic clr, input logic we, input int sel, input int dat, input logic rdy);
    in_clr[k] = clr; in_we[k] = we; in_sel[k] = sel; in_dat[k] = dat; in_rdy[k] = rdy;
  endtask

  task automatic apply_inputs();
    bus0.clr = in_clr[0]; bus0.wr_en = in_we[0]; bus0.wr_sel = in_sel[0][3:0];
    bus0.wr_data = in_dat[0][3:0]; bus0.frame_ready = in_rdy[0];
    bus1.clr = in_clr[1]; bus1.wr_en = in_we[1]; bus1.wr_sel = in_sel[1][1:0];
    bus1.wr_data = in_dat[1][3:0]; bus1.frame_ready = in_rdy[1];
    bus2.clr = in_clr[2]; bus2.wr_en = in_we[2]; bus2.wr_sel = in_sel[2][3:0];
    bus2.wr_data = in_dat[2][3:0]; bus2.frame_ready = in_rdy[2];
  endtask

  // Called at a falling edge: drive staged inputs, advance models, cross the rising
  // edge, and compare every bank at the next falling edge.
  task automatic tick();
    apply_inputs();
    for (int k = 0; k < 3; k++) begin
      mdl[k] = model_step(mdl[k], k, in_clr[k], in_we[k], in_sel[k], in_dat[k], in_rdy[k]);
    end
    @(negedge clk);
    check_all();
    idle_all();
  endtask

  initial begin
    idle_all();
    apply_inputs();
    for (int k = 0; k < 3; k++) mdl[k] = model_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Ordered fill on the one-hot bank; bad index then out-of-order fill on the binary bank.
    drive(0, 1'b0, 1'b1, 1, 3, 1'b0); drive(1, 1'b0, 1'b1, 3, 5, 1'b0); tick();
    check_eq("d1_bad_index_sel_err", {31'd0, bus1.sel_err}, 32'd1);
    drive(0, 1'b0, 1'b1, 2, 9, 1'b0); drive(1, 1'b0, 1'b1, 2, 10, 1'b0); tick();
    drive(0, 1'b0, 1'b1, 4, 1, 1'b0); drive(1, 1'b0, 1'b1, 0, 11, 1'b0); tick();
    drive(0, 1'b0, 1'b1, 8, 7, 1'b0); drive(1, 1'b0, 1'b1, 1, 12, 1'b0); tick();
    check_eq("d0_fill_flat", {16'd0, bus0.unsorted_flat}, 32'h7193);
    check_eq("d0_fill_valid", {31'd0, bus0.frame_valid}, 32'd1);
    check_eq("d1_fill_flat", {20'd0, bus1.unsorted_flat}, 32'hACB);

    // Write in HOLD is dropped; then a write coinciding with the handshake.
    drive(0, 1'b0, 1'b1, 4, 15, 1'b0); tick();
    check_eq("d0_hold_drop", {31'd0, bus0.wr_drop}, 32'd1);
    check_eq("d0_hold_flat", {16'd0, bus0.unsorted_flat}, 32'h7193);
    drive(0, 1'b0, 1'b1, 1, 5, 1'b1); drive(1, 1'b0, 1'b0, 0, 0, 1'b1); tick();
    check_eq("d0_hs_cnt", {24'd0, bus0.frame_cnt}, 32'd1);
    check_eq("d0_hs_valid", {31'd0, bus0.frame_valid}, 32'd0);
    check_eq("d0_hs_flat_kept", {16'd0, bus0.unsorted_flat}, 32'h7193);

    // Invalid one-hot select, then overwrite of slot 0.
    drive(0, 1'b0, 1'b1, 3, 5, 1'b0); tick();
    check_eq("d0_multi_hot_sel_err", {31'd0, bus0.sel_err}, 32'd1);
    drive(0, 1'b0, 1'b1, 1, 2, 1'b0); tick();
    drive(0, 1'b0, 1'b1, 1, 6, 1'b0); tick();
    check_eq("d0_ovr", {31'd0, bus0.ovr}, 32'd1);
    check_eq("d0_ovr_slot0", {28'd0, bus0.unsorted_flat[3:0]}, 32'd6);
    check_eq("d0_ovr_loaded", {28'd0, bus0.slot_loaded}, 32'd1);

    // Clear after two writes, with a write in the same cycle.
    drive(0, 1'b0, 1'b1, 2, 4, 1'b0); tick();
    drive(0, 1'b1, 1'b1, 4, 8, 1'b0); tick();
    check_eq("d0_clr_loaded", {28'd0, bus0.slot_loaded}, 32'd0);
    check_eq("d0_clr_cnt", {24'd0, bus0.frame_cnt}, 32'd1);

    // Counter wrap on the 2-bit counter bank.
    for (int f = 0; f < 4; f++) begin
      for (int s = 0; s < 4; s++) begin
        drive(2, 1'b0, 1'b1, 1 << s, $urandom_range(0, 15), 1'b0); tick();
      end
      drive(2, 1'b0, 1'b0, 0, 0, 1'b1); tick();
      check_eq($sformatf("d2_wrap_cnt_%0d", f), {30'd0, bus2.frame_cnt}, (f + 1) % 4);
    end

    // Randomised traffic on all banks.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        in_clr[k] = ($urandom_range(0, 15) == 0);
        in_we[k]  = ($urandom_range(0, 3) != 0);
        if (onehot[k] != 0) begin
          in_sel[k] = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : (1 << $urandom_range(0, 3));
        end else begin
          in_sel[k] = $urandom_range(0, 3);
        end
        in_dat[k] = $urandom_range(0, 15);
        in_rdy[k] = ($urandom_range(0, 2) == 0);
      end
      tick();
    end

    // Asynchronous reset while bank 0 holds a frame.
    drive(0, 1'b1, 1'b0, 0, 0, 1'b0); tick();
    for (int s = 0; s < 4; s++) begin
      drive(0, 1'b0, 1'b1, 1 << s, s + 5, 1'b0); tick();
    end
    check_eq("d0_pre_rst_valid", {31'd0, bus0.frame_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("d0_async_rst_valid", {31'd0, bus0.frame_valid}, 32'd0);
    check_eq("d0_async_rst_flat", {16'd0, bus0.unsorted_flat}, 32'd0);
    check_eq("d0_async_rst_loaded", {28'd0, bus0.slot_loaded}, 32'd0);
    check_eq("d0_async_rst_cnt", {24'd0, bus0.frame_cnt}, 32'd0);
    for (int k = 0; k < 3; k++) mdl[k] = model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
